voice_allocator: RTL and testbench

- Polyphony controller between the MIDI note-change decoder and a bank of NUM_VOICES oscillator/detune pipelines.
- Accepts note-on/note-off events over a valid/ready handshake and assigns each note-on to a voice: matching note first, then a free voice, else steals the oldest voice.
- Drives per-voice note, velocity, active flag and one-cycle trigger/release pulses. The trigger pulse is the oscillator clear/phase-reset.

---
 rtl/voice_allocator_pkg.sv | 36 +++
 rtl/voice_allocator_if.sv | 21 ++
 rtl/voice_allocator_age_tracker.sv | 56 +++++
 rtl/voice_allocator.sv | 204 ++++++++++++++++++++
 tb/tb_voice_allocator.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/voice_allocator_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : voice_allocator_pkg                                        |
// | Purpose  : Shared types and default sizing for the voice allocator.   |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
package voice_allocator_pkg;

   localparam int NUM_VOICES_DEFAULT = 4;
   localparam int NOTE_WIDTH_DEFAULT = 7;
   localparam int AGE_WIDTH_DEFAULT  = $clog2(NUM_VOICES_DEFAULT);

   // Full view of one voice; handy for models and debug.
   typedef struct packed {
      logic                          active;
      logic [NOTE_WIDTH_DEFAULT-1:0] note;
      logic [NOTE_WIDTH_DEFAULT-1:0] velocity;
      logic [AGE_WIDTH_DEFAULT-1:0]  age;
   } voice_state_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      COMMIT = 2'd2
   } alloc_state_t;

   typedef enum logic [2:0] {
      MATCH   = 3'd0,
      FREE    = 3'd1,
      STEAL   = 3'd2,
      RELEASE = 3'd3,
      NONE    = 3'd4
   } decision_t;

endpackage
`default_nettype wire

// File: rtl/voice_allocator_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : voice_allocator_if                                         |
// | Purpose  : Note event valid/ready channel into the voice allocator.   |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
interface voice_allocator_if
   import voice_allocator_pkg::*;
#(
   parameter int NOTE_WIDTH = NOTE_WIDTH_DEFAULT
);
   logic [NOTE_WIDTH-1:0] in_note;
   logic [NOTE_WIDTH-1:0] in_velocity;
   logic                  in_on;
   logic                  in_valid;
   logic                  in_ready;

   modport master (output in_note, in_velocity, in_on, in_valid, input in_ready);
   modport slave  (input in_note, in_velocity, in_on, in_valid, output in_ready);
endinterface
`default_nettype wire

// File: rtl/voice_allocator_age_tracker.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : voice_age_tracker                                          |
// | Purpose  : Per-voice age counters, updated once per committed event.  |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module voice_age_tracker
   import voice_allocator_pkg::*;
#(
   parameter int NUM_VOICES = NUM_VOICES_DEFAULT,
   parameter int AGE_WIDTH  = $clog2(NUM_VOICES)
) (
   input  wire logic                            clock_50_000_000,
   input  wire logic                            reset_l,
   input  wire logic                            i_commit,
   input  wire decision_t                       i_decision,
   input  wire logic [$clog2(NUM_VOICES)-1:0]   i_voice_sel,
   input  wire logic [NUM_VOICES-1:0]           i_active,
   output logic      [NUM_VOICES*AGE_WIDTH-1:0] o_ages
);
   localparam logic [AGE_WIDTH-1:0] C_AGE_MAX = AGE_WIDTH'(NUM_VOICES - 1);

   logic [AGE_WIDTH-1:0] r_age [NUM_VOICES];
   logic [AGE_WIDTH-1:0] w_sel_age;

   assign w_sel_age = r_age[i_voice_sel];

   // Chosen voice becomes youngest; others age according to how it was chosen.
   always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
      if (!reset_l) begin
         for (int i = 0; i < NUM_VOICES; i++) r_age[i] <= '0;
      end else if (i_commit && i_decision != NONE) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (i == int'(i_voice_sel)) begin
               r_age[i] <= '0;
            end else if (i_active[i]) begin
               case (i_decision)
                  FREE:
                     if (r_age[i] != C_AGE_MAX) r_age[i] <= r_age[i] + AGE_WIDTH'(1);
                  MATCH, STEAL:
                     // Only voices younger than the reused one move up, keeping ages unique.
                     if (r_age[i] < w_sel_age) r_age[i] <= r_age[i] + AGE_WIDTH'(1);
                  default: ;
               endcase
            end
         end
      end
   end

   generate
      for (genvar g = 0; g < NUM_VOICES; g++) begin : g_age_out
         assign o_ages[g*AGE_WIDTH +: AGE_WIDTH] = r_age[g];
      end
   endgenerate
endmodule
`default_nettype wire

// File: rtl/voice_allocator.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : voice_allocator                                            |
// | Purpose  : Assigns note-on/off events to voices: match, free, steal.  |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module voice_allocator
   import voice_allocator_pkg::*;
#(
   parameter int NUM_VOICES = NUM_VOICES_DEFAULT,
   parameter int NOTE_WIDTH = NOTE_WIDTH_DEFAULT,
   parameter int AGE_WIDTH  = $clog2(NUM_VOICES)
) (
   input  wire logic                             clock_50_000_000,
   input  wire logic                             reset_l,
   voice_allocator_if.slave                      evt,
   output logic      [NUM_VOICES-1:0]            voice_active,
   output logic      [NUM_VOICES*NOTE_WIDTH-1:0] voice_note,
   output logic      [NUM_VOICES*NOTE_WIDTH-1:0] voice_velocity,
   output logic      [NUM_VOICES-1:0]            voice_trigger,
   output logic      [NUM_VOICES-1:0]            voice_release,
   output logic                                  steal
);
   localparam int                   IDX_WIDTH  = $clog2(NUM_VOICES);
   localparam logic [IDX_WIDTH-1:0] C_LAST_IDX = IDX_WIDTH'(NUM_VOICES - 1);

   alloc_state_t r_state, w_state_next;
   logic         w_ready, w_accept, w_commit;

   logic                  r_evt_on;
   logic [NOTE_WIDTH-1:0] r_evt_note, r_evt_vel;

   logic [IDX_WIDTH-1:0] r_idx;
   logic                 r_match_found, r_free_found, r_old_found;
   logic [IDX_WIDTH-1:0] r_match_idx, r_free_idx, r_old_idx;
   logic [AGE_WIDTH-1:0] r_old_age;

   logic [NUM_VOICES-1:0]  r_active, r_trigger, r_release;
   logic [NOTE_WIDTH-1:0]  r_note [NUM_VOICES];
   logic [NOTE_WIDTH-1:0]  r_vel  [NUM_VOICES];
   logic                   r_steal;

   logic [NUM_VOICES*AGE_WIDTH-1:0] w_ages;
   logic [AGE_WIDTH-1:0]            w_scan_age;
   decision_t                       w_decision;
   logic [IDX_WIDTH-1:0]            w_sel;

   assign w_scan_age   = w_ages[r_idx*AGE_WIDTH +: AGE_WIDTH];
   assign evt.in_ready = w_ready;

   // State register.
   always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
      if (!reset_l) r_state <= IDLE;
      else          r_state <= w_state_next;
   end

   // Next-state and handshake decode.
   always_comb begin
      w_state_next = r_state;
      w_ready      = 1'b0;
      w_accept     = 1'b0;
      w_commit     = 1'b0;
      case (r_state)
         IDLE: begin
            w_ready = 1'b1;
            if (evt.in_valid) begin
               w_accept     = 1'b1;
               w_state_next = SCAN;
            end
         end
         SCAN:    if (r_idx == C_LAST_IDX) w_state_next = COMMIT;
         COMMIT: begin
            w_commit     = 1'b1;
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Latch the accepted event, then walk the voices recording candidates.
   always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
      if (!reset_l) begin
         r_evt_on      <= 1'b0;
         r_evt_note    <= '0;
         r_evt_vel     <= '0;
         r_idx         <= '0;
         r_match_found <= 1'b0;
         r_free_found  <= 1'b0;
         r_old_found   <= 1'b0;
         r_match_idx   <= '0;
         r_free_idx    <= '0;
         r_old_idx     <= '0;
         r_old_age     <= '0;
      end else if (w_accept) begin
         r_evt_note    <= evt.in_note;
         r_evt_vel     <= evt.in_velocity;
         // Zero-velocity note-on is a note-off by MIDI convention.
         r_evt_on      <= evt.in_on && (evt.in_velocity != '0);
         r_idx         <= '0;
         r_match_found <= 1'b0;
         r_free_found  <= 1'b0;
         r_old_found   <= 1'b0;
         r_old_age     <= '0;
      end else if (r_state == SCAN) begin
         if (r_active[r_idx] && r_note[r_idx] == r_evt_note && !r_match_found) begin
            r_match_found <= 1'b1;
            r_match_idx   <= r_idx;
         end
         if (!r_active[r_idx] && !r_free_found) begin
            r_free_found <= 1'b1;
            r_free_idx   <= r_idx;
         end
         // Strict compare so ties keep the lowest index.
         if (r_active[r_idx] && (!r_old_found || w_scan_age > r_old_age)) begin
            r_old_found <= 1'b1;
            r_old_idx   <= r_idx;
            r_old_age   <= w_scan_age;
         end
         r_idx <= r_idx + IDX_WIDTH'(1);
      end
   end

   // Resolve the scan results into one decision and target voice.
   always_comb begin
      w_decision = NONE;
      w_sel      = '0;
      if (r_evt_on) begin
         if (r_match_found) begin
            w_decision = MATCH;
            w_sel      = r_match_idx;
         end else if (r_free_found) begin
            w_decision = FREE;
            w_sel      = r_free_idx;
         end else begin
            w_decision = STEAL;
            w_sel      = r_old_idx;
         end
      end else if (r_match_found) begin
         w_decision = RELEASE;
         w_sel      = r_match_idx;
      end
   end

   // Voice outputs change only on commit; pulses self-clear the next cycle.
   always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
      if (!reset_l) begin
         r_active  <= '0;
         r_trigger <= '0;
         r_release <= '0;
         r_steal   <= 1'b0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            r_note[i] <= '0;
            r_vel[i]  <= '0;
         end
      end else begin
         r_trigger <= '0;
         r_release <= '0;
         r_steal   <= 1'b0;
         if (w_commit) begin
            case (w_decision)
               MATCH, FREE, STEAL: begin
                  r_active[w_sel]  <= 1'b1;
                  r_note[w_sel]    <= r_evt_note;
                  r_vel[w_sel]     <= r_evt_vel;
                  r_trigger[w_sel] <= 1'b1;
                  r_steal          <= (w_decision == STEAL);
               end
               // Note and velocity are kept for the envelope tail.
               RELEASE: begin
                  r_active[w_sel]  <= 1'b0;
                  r_release[w_sel] <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   voice_age_tracker #(
      .NUM_VOICES (NUM_VOICES),
      .AGE_WIDTH  (AGE_WIDTH)
   ) u_age_tracker (
      .clock_50_000_000 (clock_50_000_000),
      .reset_l          (reset_l),
      .i_commit         (w_commit),
      .i_decision       (w_decision),
      .i_voice_sel      (w_sel),
      .i_active         (r_active),
      .o_ages           (w_ages)
   );

   generate
      for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice_out
         assign voice_note[g*NOTE_WIDTH +: NOTE_WIDTH]     = r_note[g];
         assign voice_velocity[g*NOTE_WIDTH +: NOTE_WIDTH] = r_vel[g];
      end
   endgenerate

   assign voice_active  = r_active;
   assign voice_trigger = r_trigger;
   assign voice_release = r_release;
   assign steal         = r_steal;
endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_voice_allocator                                         |
// | Purpose  : Directed plus random events against a behavioural model.   |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module tb_voice_allocator;
   import voice_allocator_pkg::*;

   localparam int NV = 4;
   localparam int NW = 7;

   logic clock_50_000_000 = 1'b0;
   logic reset_l;

   logic [NV-1:0]    voice_active, voice_trigger, voice_release;
   logic [NV*NW-1:0] voice_note, voice_velocity;
   logic             steal;

   voice_allocator_if #(.NOTE_WIDTH(NW)) ev ();

   voice_allocator #(.NUM_VOICES(NV), .NOTE_WIDTH(NW)) dut (
      .clock_50_000_000 (clock_50_000_000),
      .reset_l          (reset_l),
      .evt              (ev),
      .voice_active     (voice_active),
      .voice_note       (voice_note),
      .voice_velocity   (voice_velocity),
      .voice_trigger    (voice_trigger),
      .voice_release    (voice_release),
      .steal            (steal)
   );

   always #5 clock_50_000_000 = ~clock_50_000_000;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference model: one record per voice plus the pulses of the last event.
   voice_state_t m [NV];
   logic [NV-1:0] e_trig, e_rel;
   logic          e_steal;

   task automatic model_reset();
      for (int i = 0; i < NV; i++) m[i] = '0;
      e_trig = '0; e_rel = '0; e_steal = 1'b0;
   endtask

   task automatic model_apply(input logic [NW-1:0] n, input logic [NW-1:0] v, input bit on);
      int match, free, old, sel, a;
      bit new_alloc;
      e_trig = '0; e_rel = '0; e_steal = 1'b0;
      match = -1; free = -1; old = -1;
      for (int i = NV - 1; i >= 0; i--) begin
         if (m[i].active && m[i].note == n) match = i;
         if (!m[i].active) free = i;
      end
      for (int i = 0; i < NV; i++)
         if (m[i].active && (old < 0 || int'(m[i].age) > int'(m[old].age))) old = i;
      if (on && v != 0) begin
         new_alloc = 1'b0;
         if (match >= 0) sel = match;
         else if (free >= 0) begin sel = free; new_alloc = 1'b1; end
         else begin sel = old; e_steal = 1'b1; end
         a = int'(m[sel].age);
         for (int i = 0; i < NV; i++) begin
            if (i != sel && m[i].active) begin
               if (new_alloc) begin
                  if (int'(m[i].age) < NV - 1) m[i].age = m[i].age + 1'b1;
               end else if (int'(m[i].age) < a) m[i].age = m[i].age + 1'b1;
            end
         end
         m[sel].active   = 1'b1;
         m[sel].note     = n;
         m[sel].velocity = v;
         m[sel].age      = '0;
         e_trig[sel]     = 1'b1;
      end else if (match >= 0) begin
         m[match].active = 1'b0;
         m[match].age    = '0;
         e_rel[match]    = 1'b1;
      end
   endtask

   function automatic logic [NV-1:0] m_active();
      logic [NV-1:0] r;
      for (int i = 0; i < NV; i++) r[i] = m[i].active;
      return r;
   endfunction

   function automatic logic [NV*NW-1:0] m_notes(input bit vel);
      logic [NV*NW-1:0] r;
      for (int i = 0; i < NV; i++) r[i*NW +: NW] = vel ? m[i].velocity : m[i].note;
      return r;
   endfunction

   function automatic logic [127:0] dut_all();
      return 128'({voice_active, voice_note, voice_velocity, voice_trigger, voice_release, steal});
   endfunction

   function automatic logic [127:0] model_quiet();
      return 128'({m_active(), m_notes(1'b0), m_notes(1'b1), {NV{1'b0}}, {NV{1'b0}}, 1'b0});
   endfunction

   // Called at a negedge; returns at a negedge one cycle after the result appears.
   task automatic send(input logic [NW-1:0] n, input logic [NW-1:0] v, input bit on);
      int busy;
      logic [127:0] prev;
      ev.in_note = n; ev.in_velocity = v; ev.in_on = on; ev.in_valid = 1'b1;
      for (int k = 0; k < 20 && ev.in_ready !== 1'b1; k++) @(negedge clock_50_000_000);
      if (ev.in_ready !== 1'b1) begin
         check_eq("accept_timeout", 128'(ev.in_ready), 128'(1));
         ev.in_valid = 1'b0;
         return;
      end
      @(posedge clock_50_000_000);
      prev = model_quiet();
      model_apply(n, v, on);
      busy = 0;
      @(negedge clock_50_000_000);
      while (ev.in_ready !== 1'b1 && busy < 20) begin
         busy++;
         if (busy == 2) check_eq("stable_in_scan", dut_all(), prev);
         // Offers made while busy must be ignored.
         if (busy <= NV) begin
            ev.in_valid    = 1'($urandom_range(0, 1));
            ev.in_note     = NW'($urandom);
            ev.in_velocity = NW'($urandom);
            ev.in_on       = 1'($urandom);
         end else ev.in_valid = 1'b0;
         @(negedge clock_50_000_000);
      end
      ev.in_valid = 1'b0;
      check_eq("busy_cycles", 128'(busy), 128'(NV + 1));
      check_eq("active",   128'(voice_active),   128'(m_active()));
      check_eq("note",     128'(voice_note),     128'(m_notes(1'b0)));
      check_eq("velocity", 128'(voice_velocity), 128'(m_notes(1'b1)));
      check_eq("trigger",  128'(voice_trigger),  128'(e_trig));
      check_eq("release",  128'(voice_release),  128'(e_rel));
      check_eq("steal",    128'(steal),          128'(e_steal));
      @(negedge clock_50_000_000);
      check_eq("pulse_clear", 128'({voice_trigger, voice_release, steal}), 128'(0));
   endtask

   initial begin
      logic [NW-1:0] rn, rv;
      bit ron;
      reset_l = 1'b0;
      ev.in_valid = 1'b0; ev.in_note = '0; ev.in_velocity = '0; ev.in_on = 1'b0;
      model_reset();
      repeat (3) @(negedge clock_50_000_000);
      reset_l = 1'b1;
      @(negedge clock_50_000_000);
      check_eq("rst_ready",   128'(ev.in_ready), 128'(1));
      check_eq("rst_outputs", dut_all(),         128'(0));

      // Directed walk through allocation, steal, retrigger and release.
      send(7'd60, 7'd100, 1'b1);
      send(7'd62, 7'd100, 1'b1);
      send(7'd64, 7'd90,  1'b1);
      send(7'd65, 7'd80,  1'b1);
      send(7'd67, 7'd70,  1'b1);
      send(7'd62, 7'd50,  1'b1);
      send(7'd62, 7'd0,   1'b0);
      send(7'd70, 7'd10,  1'b0);
      send(7'd64, 7'd0,   1'b1);

      // Reset while an event is being scanned; the source keeps offering it.
      ev.in_note = 7'd72; ev.in_velocity = 7'd90; ev.in_on = 1'b1; ev.in_valid = 1'b1;
      @(posedge clock_50_000_000);
      @(negedge clock_50_000_000);
      @(negedge clock_50_000_000);
      reset_l = 1'b0;
      #1;
      check_eq("midscan_rst_outputs", dut_all(),         128'(0));
      check_eq("midscan_rst_ready",   128'(ev.in_ready), 128'(1));
      model_reset();
      @(negedge clock_50_000_000);
      reset_l = 1'b1;
      check_eq("post_rst_ready", 128'(ev.in_ready), 128'(1));
      send(7'd72, 7'd90, 1'b1);

      // Random traffic over a narrow note range so matches and steals are frequent.
      for (int k = 0; k < 200; k++) begin
         rn  = NW'(60 + $urandom_range(0, 9));
         rv  = ($urandom_range(0, 4) == 0) ? 7'd0 : NW'($urandom_range(1, 127));
         ron = ($urandom_range(0, 9) < 7);
         send(rn, rv, ron);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
